// File: rtl/mult16_seq_pkg.sv
// Shared definitions for the 16-bit sequential shift-add multiplier.
package mult16_seq_pkg;

  // Datapath width of operands, accumulator and result
  localparam int WIDTH = 16;

  // Iteration counter width (counts 0 .. ITERS-1 with headroom)
  localparam int CNT_W = 5;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : mult16_seq_pkg

// File: rtl/mult16_seq_add16.sv
// 16-bit adder; the sum wraps modulo 2^16 and the carry is discarded.
module mult16_seq_add16
  import mult16_seq_pkg::*;
(
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum
);

  // Plain wrapping addition; the carry out is deliberately not kept
  assign sum = x + y;

endmodule : mult16_seq_add16

// File: rtl/mult16_seq.sv
// Sequential shift-add multiplier returning the low 16 bits of a*b.
// One partial product is folded in per clock for ITERS cycles.
module mult16_seq
  import mult16_seq_pkg::*;
#(
  parameter int ITERS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] out_q,    out_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] acc_step_s;

  // Single shared adder: accumulator plus shifted multiplicand
  mult16_seq_add16 u_add16 (
    .x   (acc_q),
    .y   (mcand_q),
    .sum (sum_s)
  );

  // Accumulator value after the current iteration (add only when multiplier LSB set)
  assign acc_step_s = mplier_q[0] ? sum_s : acc_q;

  // Next-state and datapath update for the IDLE/RUN/DONE controller
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    out_d    = out_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = {WIDTH{1'b0}};
          cnt_d    = {CNT_W{1'b0}};
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        acc_d    = acc_step_s;
        mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 5'd1;
        // Always run the full ITERS iterations, even once mplier is zero
        if (cnt_q == LAST_CNT) begin
          out_d   = acc_step_s;
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      out_q    <= {WIDTH{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
    end
  end

  // Status flags decoded purely from the state register
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign out  = out_q;

endmodule : mult16_seq

// File: tb/tb_mult16_seq.sv
// Directed and random self-checking bench for mult16_seq.
module tb_mult16_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] out;
  logic        busy;
  logic        done;

  int n_tests;
  int n_fail;

  mult16_seq #(.ITERS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if observed differs from expected
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Run one multiply from IDLE (called at a negedge); optionally re-pulse start
  // with operands 9,9 at RUN cycle 'inject' (negative disables it).
  task automatic do_op(input logic [15:0] a_i, input logic [15:0] b_i,
                       input logic [15:0] exp_i, input int inject, input string tag);
    logic [15:0] prev;
    int          busy_cyc;
    bit          got;
    prev  = out;
    a     = a_i;
    b     = b_i;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = ~a_i;
    b     = ~b_i;
    check({tag, ":out_hold_on_start"}, {16'd0, out}, {16'd0, prev});
    busy_cyc = 0;
    got      = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (done) begin
        got = 1'b1;
      end else begin
        if (busy) busy_cyc++;
        if (i == inject) begin
          start = 1'b1;
          a     = 16'd9;
          b     = 16'd9;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    check({tag, ":done_seen"}, {31'd0, got}, 32'd1);
    check({tag, ":busy_cycles"}, busy_cyc, 32'd16);
    check({tag, ":out"}, {16'd0, out}, {16'd0, exp_i});
    check({tag, ":busy_at_done"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    check({tag, ":done_single"}, {31'd0, done}, 32'd0);
    check({tag, ":out_hold_idle"}, {16'd0, out}, {16'd0, exp_i});
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [31:0] prod;
    int          n_done;

    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    start   = 1'b0;
    a       = 16'd0;
    b       = 16'd0;
    repeat (2) @(negedge clk);
    check("reset:busy", {31'd0, busy}, 32'd0);
    check("reset:done", {31'd0, done}, 32'd0);
    check("reset:out",  {16'd0, out},  32'd0);
    reset = 1'b0;

    // First start right after reset release, then directed vectors
    do_op(16'd3,     16'd5,     16'h000F, -1, "basic");
    do_op(16'hFFFE,  16'd7,     16'hFFF2, -1, "signed");
    do_op(16'h0100,  16'h0100,  16'h0000, -1, "wrap100");
    do_op(16'hFFFF,  16'hFFFF,  16'h0001, -1, "wrapffff");
    do_op(16'd0,     16'h1234,  16'h0000, -1, "zero");
    do_op(16'h8000,  16'd1,     16'h8000, -1, "msb");

    // Start during RUN must be ignored with nothing left pending
    do_op(16'd3, 16'd5, 16'h000F, 5, "ignore");
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) n_done++;
      @(negedge clk);
    end
    check("ignore:no_second_op", n_done, 32'd0);
    check("ignore:out_kept", {16'd0, out}, 32'h000F);

    // Reset during RUN cycle 8 discards the operation
    a     = 16'h1234;
    b     = 16'h5678;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("midreset:busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset:busy", {31'd0, busy}, 32'd0);
    check("midreset:done", {31'd0, done}, 32'd0);
    check("midreset:out",  {16'd0, out},  32'd0);
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    check("midreset:no_done", n_done, 32'd0);
    do_op(16'd6, 16'd7, 16'd42, -1, "after_reset");

    // Random vectors: {a, b, expected} with expected from a full product
    for (int v = 0; v < 1000; v++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      prod = {16'd0, ra} * {16'd0, rb};
      do_op(ra, rb, prod[15:0], -1, $sformatf("rand%0d", v));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mult16_seq

// File: doc/mult16_seq.md
MULT16_SEQ -- requirements
Module: mult16_seq

Interface
REQ-001 The block SHALL expose: clk  input  1  system clock, all state updates on its rising edge.
REQ-002 The block SHALL expose: reset  input  1  synchronous, active-high reset.
REQ-003 The block SHALL expose: start  input  1  request to begin a multiply, sampled on a rising clk edge.
REQ-004 The block SHALL expose: a  input  16  multiplicand, captured when start is accepted.
REQ-005 The block SHALL expose: b  input  16  multiplier, captured when start is accepted.
REQ-006 The block SHALL expose: out  output  16  low 16 bits of a*b, registered.
REQ-007 The block SHALL expose: busy  output  1  high while an operation is in progress.
REQ-008 The block SHALL expose: done  output  1  single-cycle pulse marking out as newly valid.
REQ-009 The block SHALL have one parameter: ITERS, default 16, meaning the number of shift-add iterations (fixed at 16 for Hack).

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-011 In IDLE, start=1 on an edge SHALL be accepted, with these actions on that edge: mcand<=a, mplier<=b, acc<=0, cnt<=0, state<=RUN.
REQ-012 Start SHALL be accepted only in IDLE; start in RUN or DONE SHALL be ignored, leaving no pending request.
REQ-013 Each RUN edge SHALL perform these actions: if mplier[0]=1 then acc<=acc+mcand, else acc unchanged; mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1.
REQ-014 All additions SHALL be computed by one Add16 instance, and results SHALL wrap modulo 2^16 with no carry or overflow output.
REQ-015 The result SHALL be the low 16 bits of the product, identical for the two's-complement signed and the unsigned interpretation.
REQ-016 RUN SHALL last exactly ITERS edges, with no early termination when mplier becomes zero.
REQ-017 On the edge completing iteration ITERS-1 (cnt=ITERS-1), the block SHALL set out<=final acc and state<=DONE.
REQ-018 DONE SHALL last one cycle and then return to IDLE unconditionally.
REQ-019 Latency: for start accepted at edge k, done SHALL be high only in the cycle following edge k+16, and out SHALL be valid from that cycle on.
REQ-020 out SHALL hold its last result through IDLE and RUN until the next completion, and SHALL NOT change on start acceptance.
REQ-021 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; both are decoded from registered state with no combinational path from start.
REQ-022 Changes to a and b after acceptance SHALL have no effect on the operation in progress.

Reset
REQ-023 When reset=1 on an edge, the block SHALL set state<=IDLE, out<=0, acc<=0, mcand<=0, mplier<=0 and cnt<=0, so that busy=0 and done=0.
REQ-024 Reset SHALL take priority over start and over any in-progress RUN or DONE, discarding the partial result without producing a done pulse.
REQ-025 The first start after reset is released SHALL be accepted normally on the next edge with reset=0.

Structure
REQ-026 The state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the width constant 16 SHALL reside in the shared Hack definitions header.
REQ-027 Add16 SHALL be the only sub-module, instantiated once with inputs acc and mcand; the remaining logic (FSM, shift registers, 5-bit counter) SHALL be local.

Verification
REQ-028 Basic case: a=3, b=5, start pulsed one cycle -> busy for 16 cycles, then a single done pulse with out=15 (0x000F).
REQ-029 Signed case: a=0xFFFE (-2), b=7 -> out=0xFFF2 (-14) at done.
REQ-030 Wrap case: a=0x0100, b=0x0100 -> out=0x0000; and a=0xFFFF, b=0xFFFF -> out=0x0001.
REQ-031 Busy ignore: start re-asserted with new operands (9, 9) at cycle 5 of RUN -> first result 15 is unaffected, exactly one done pulse occurs, and the block returns to IDLE with no second operation.
REQ-032 Reset mid-op: reset asserted at RUN cycle 8 -> next edge gives busy=0, done=0, out=0, and no done pulse follows; a subsequent a=6, b=7 yields out=42.
REQ-033 Randomized check: 1000 vectors in {a, b, expected} test-vector format -> every done pulse shows out == (a*b) mod 65536, with zero errors reported.
